// File: rtl/seg_pkg.sv
// Shared types and helpers for the 7-segment scan controller.
// The optional feature macro SEG_LEADING_ZERO_BLANK_EN is consumed by seg_scan_ctrl.
package seg_pkg;

    localparam int NIB_W = 4;

    typedef enum logic [0:0] {
        GUARD = 1'b0,
        DRIVE = 1'b1
    } scan_state_t;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++)
            if ((1 << i) < v) r = i + 1;
        return r;
    endfunction

endpackage

// File: rtl/seg_scan_ctrl_if.sv
// Frame write channel: valid/ready handshake carrying nibbles, dp and blank masks.
interface seg_scan_ctrl_if #(parameter int NUM_DIGITS = 4);
    import seg_pkg::*;

    logic                          valid;
    logic                          ready;
    logic [NIB_W*NUM_DIGITS-1:0]   data;
    logic [NUM_DIGITS-1:0]         dp;
    logic [NUM_DIGITS-1:0]         blank;

    modport master (output valid, data, dp, blank, input ready);
    modport slave  (input valid, data, dp, blank, output ready);
endinterface

// File: rtl/seg_scan_timer.sv
// Free-running slot counter; tc flags the terminal value, load restarts from zero.
module seg_scan_timer #(
    parameter int CW = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [CW-1:0] last,
    input  logic          load,
    output logic          tc
);
    logic [CW-1:0] cnt;

    assign tc = (cnt == last);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)    cnt <= '0;
        else if (load) cnt <= '0;
        else           cnt <= cnt + 1'b1;
    end
endmodule

// File: rtl/seg_scan_ctrl.sv
// Multiplexed common-anode 7-seg scan controller with guard blanking and tear-free frame commit.
// Optional: SEG_LEADING_ZERO_BLANK_EN auto-blanks leading zero digits at commit.
module seg_scan_ctrl
    import seg_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int DWELL_CYC  = 100000,
    parameter int GUARD_CYC  = 1000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    seg_scan_ctrl_if.slave        wr,
    output logic [NIB_W-1:0]      nib_out,
    output logic                  dp_n,
    output logic [NUM_DIGITS-1:0] an_n,
    output logic                  frame_sync
);
    localparam int MAXC = (DWELL_CYC > GUARD_CYC) ? DWELL_CYC : GUARD_CYC;
    localparam int CW   = clog2(MAXC);
    localparam int IW   = clog2(NUM_DIGITS);
    localparam logic [CW-1:0] G_LAST   = CW'(GUARD_CYC - 1);
    localparam logic [CW-1:0] D_LAST   = CW'(DWELL_CYC - 1);
    localparam logic [IW-1:0] LAST_IDX = IW'(NUM_DIGITS - 1);

    scan_state_t st;
    logic [IW-1:0] idx;
    logic [CW-1:0] cnt_last;
    logic          tc;
    logic          boundary;

    logic [NUM_DIGITS-1:0][NIB_W-1:0] disp_data, pend_data;
    logic [NUM_DIGITS-1:0]            disp_dp, disp_blank, pend_dp, pend_blank;
    logic [NUM_DIGITS-1:0]            auto_bl;
    logic                             pend_full;

    assign cnt_last = (st == GUARD) ? G_LAST : D_LAST;
    assign boundary = (st == DRIVE) && tc && (idx == LAST_IDX);
    assign wr.ready = ~pend_full;

    // One counter serves both phases: it restarts whenever the phase ends.
    seg_scan_timer #(.CW(CW)) u_tmr (
        .clk   (clk),
        .rst_n (rst_n),
        .last  (cnt_last),
        .load  (tc),
        .tc    (tc)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st  <= GUARD;
            idx <= '0;
        end else if (tc) begin
            st <= (st == GUARD) ? DRIVE : GUARD;
            if (st == DRIVE) idx <= (idx == LAST_IDX) ? '0 : idx + 1'b1;
        end
    end

`ifdef SEG_LEADING_ZERO_BLANK_EN
    // zc[i]: digit i and every digit above it hold zero.
    logic [NUM_DIGITS:1] zc;
    assign zc[NUM_DIGITS] = 1'b1;
    assign auto_bl[0]     = 1'b0;
    for (genvar i = NUM_DIGITS - 1; i >= 1; i--) begin : g_lzb
        assign zc[i]      = zc[i+1] & (pend_data[i] == '0);
        assign auto_bl[i] = zc[i];
    end
`else
    assign auto_bl = '0;
`endif

    // Pending buffer only drains at the frame boundary, so a frame is never shown half-updated.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            disp_data  <= '0;
            disp_dp    <= '0;
            disp_blank <= '1;
            pend_data  <= '0;
            pend_dp    <= '0;
            pend_blank <= '1;
            pend_full  <= 1'b0;
        end else if (boundary && pend_full) begin
            disp_data  <= pend_data;
            disp_dp    <= pend_dp & ~auto_bl;
            disp_blank <= pend_blank | auto_bl;
            pend_full  <= 1'b0;
        end else if (wr.valid && !pend_full) begin
            pend_data  <= wr.data;
            pend_dp    <= wr.dp;
            pend_blank <= wr.blank;
            pend_full  <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            an_n       <= '1;
            nib_out    <= '0;
            dp_n       <= 1'b1;
            frame_sync <= 1'b0;
        end else begin
            an_n       <= '1;
            frame_sync <= boundary;
            if (st == DRIVE) begin
                nib_out <= disp_data[idx];
                dp_n    <= ~disp_dp[idx];
                if (!disp_blank[idx]) an_n[idx] <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Randomized + directed bench for seg_scan_ctrl against a slot-arithmetic display model.
module tb_seg_scan_ctrl;
    localparam int N = 4, D = 4, G = 2;
    localparam int SLOT = G + D;
    localparam int PER  = N * SLOT;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] nib_out;
    logic       dp_n;
    logic [3:0] an_n;
    logic       frame_sync;

    seg_scan_ctrl_if #(.NUM_DIGITS(N)) wif ();

    seg_scan_ctrl #(.NUM_DIGITS(N), .DWELL_CYC(D), .GUARD_CYC(G)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .wr         (wif),
        .nib_out    (nib_out),
        .dp_n       (dp_n),
        .an_n       (an_n),
        .frame_sync (frame_sync)
    );

    always #5 clk = ~clk;

    int checks = 0, errors = 0;

    // model state: k = clock edges since reset release
    int          k, last_fs;
    logic [15:0] m_data, p_data;
    logic [3:0]  m_dp, m_bl, p_dp, p_bl;
    logic        p_full, acc_last, chk_an3;
    logic [3:0]  exp_an, exp_nib;
    logic        exp_dpn, exp_fs;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        k = 0; last_fs = -1;
        m_data = '0; m_dp = '0; m_bl = '1;
        p_data = '0; p_dp = '0; p_bl = '1; p_full = 1'b0;
        exp_an = '1; exp_nib = '0; exp_dpn = 1'b1; exp_fs = 1'b0;
        acc_last = 1'b0;
    endtask

    task automatic commit();
        m_data = p_data; m_dp = p_dp; m_bl = p_bl;
`ifdef SEG_LEADING_ZERO_BLANK_EN
        for (int i = N - 1; i >= 1; i--) begin
            if (m_data[4*i +: 4] != 4'h0) break;
            m_bl[i] = 1'b1;
            m_dp[i] = 1'b0;
        end
`endif
    endtask

    // Effect of one clock edge: outputs reflect the slot position of the cycle just ended.
    task automatic model_edge();
        int p, s;
        logic drive, acc;
        p = k % PER; s = p / SLOT; drive = (p % SLOT) >= G;
        exp_an = 4'hF;
        if (drive && !m_bl[s]) exp_an[s] = 1'b0;
        if (drive) begin
            exp_nib = m_data[4*s +: 4];
            exp_dpn = ~m_dp[s];
        end
        exp_fs = (p == PER - 1);
        acc = wif.valid && !p_full;
        if (exp_fs && p_full) begin
            commit();
            p_full = 1'b0;
        end
        if (acc) begin
            p_data = wif.data; p_dp = wif.dp; p_bl = wif.blank; p_full = 1'b1;
        end
        acc_last = acc;
        k++;
    endtask

    task automatic check_outputs();
        chk("an_n", an_n, exp_an);
        chk("nib_out", nib_out, exp_nib);
        chk("dp_n", dp_n, exp_dpn);
        chk("frame_sync", frame_sync, exp_fs);
        chk("wr_ready", wif.ready, !p_full);
        if (chk_an3) chk("an3_dark", an_n[3], 1'b1);
        if (frame_sync) begin
            if (last_fs >= 0) chk("fs_period", k - last_fs, PER);
            last_fs = k;
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_outputs();
    endtask

    task automatic present(input logic [15:0] d, input logic [3:0] p, input logic [3:0] b);
        wif.valid = 1'b1; wif.data = d; wif.dp = p; wif.blank = b;
    endtask

    task automatic send(input logic [15:0] d, input logic [3:0] p, input logic [3:0] b);
        present(d, p, b);
        for (int i = 0; i < 100; i++) begin
            step();
            if (acc_last) break;
        end
        chk("accept_timeout", acc_last, 1'b1);
        wif.valid = 1'b0;
    endtask

    initial begin
        rst_n = 1'b1; chk_an3 = 1'b0;
        wif.valid = 1'b0; wif.data = '0; wif.dp = '0; wif.blank = '0;
        model_reset();
        #1 rst_n = 1'b0;
        #2;
        chk("rst_an_n", an_n, 4'hF);
        chk("rst_nib", nib_out, 4'h0);
        chk("rst_dp_n", dp_n, 1'b1);
        chk("rst_fs", frame_sync, 1'b0);
        chk("rst_ready", wif.ready, 1'b1);
        repeat (3) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;

        // idle: dark display, periodic frame_sync
        repeat (100) step();

        // first frame, then back-to-back frames with the second held off
        send(16'h1234, 4'b0100, 4'b0000);
        repeat (2 * PER) step();
        send(16'h5678, 4'b0001, 4'b0000);
        send(16'hABCD, 4'b1010, 4'b0000);
        repeat (3 * PER) step();

        // digit 3 blanked: never lit, slot timing unchanged
        send(16'hF00F, 4'b1111, 4'b1000);
        repeat (2 * PER + 2) step();
        chk_an3 = 1'b1;
        repeat (3 * PER) step();
        chk_an3 = 1'b0;

        // random traffic with source-held valid
        for (int c = 0; c < 800; c++) begin
            if (!wif.valid && $urandom_range(0, 5) == 0)
                present(16'($urandom), 4'($urandom), 4'($urandom));
            step();
            if (acc_last) wif.valid = 1'b0;
        end
        wif.valid = 1'b0;

        // reset while digit 2 is lit and a frame is pending
        for (int i = 0; i < 300; i++) begin
            if (p_full && (k % PER) == 2 * SLOT + 3 && !m_bl[2]) break;
            if (!p_full && !wif.valid) present(16'($urandom), 4'($urandom), 4'b0000);
            step();
            if (acc_last) wif.valid = 1'b0;
        end
        wif.valid = 1'b0;
        chk("pre_rst_an_n", an_n, 4'b1011);
        chk("pre_rst_ready", wif.ready, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_an_n", an_n, 4'hF);
        chk("mid_rst_nib", nib_out, 4'h0);
        chk("mid_rst_dp_n", dp_n, 1'b1);
        chk("mid_rst_ready", wif.ready, 1'b1);
        model_reset();
        @(negedge clk) rst_n = 1'b1;
        repeat (3 * PER) step();

`ifdef SEG_LEADING_ZERO_BLANK_EN
        send(16'h0050, 4'b1111, 4'b0000);
        repeat (3 * PER) step();
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
